// File: rtl/pos_to_remote_packer.sv
// Packs four outgoing position sub-packets into one 512-bit AXI-Stream beat.
// Slot layout and slot order mirror the receive-side remote-position unpacker.
module pos_to_remote_packer #(
    parameter int AXIS_TDATA_WIDTH     = 512,
    parameter int NUM_SUB_PACKETS      = 4,
    parameter int SUB_PACKET_WIDTH     = 128,
    parameter int OFFSET_WIDTH         = 29,
    parameter int NB_CELL_COUNT_WIDTH  = 5,
    parameter int GLOBAL_CELL_ID_WIDTH = 4,
    parameter int ELEMENT_WIDTH        = 2,
    parameter int PARTICLE_ID_WIDTH    = 9
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic [3*OFFSET_WIDTH+ELEMENT_WIDTH+PARTICLE_ID_WIDTH-1:0] i_offset_pkt,
    input  logic [3*GLOBAL_CELL_ID_WIDTH-1:0]                      i_gcid,
    input  logic [NB_CELL_COUNT_WIDTH-1:0]                         i_lifetime,
    input  logic                                                   i_last,
    input  logic                                                   i_valid,
    output logic                                                   o_ready,
    output logic [AXIS_TDATA_WIDTH-1:0]                            o_remote_tdata,
    output logic                                                   o_remote_tvalid,
    output logic                                                   o_remote_tlast,
    input  logic                                                   i_remote_tready,
    output logic [31:0]                                            o_beat_cnt
);

    localparam int GCID_W    = 3*GLOBAL_CELL_ID_WIDTH;
    localparam int FILL_W    = $clog2(NUM_SUB_PACKETS);
    localparam int LAST_BIT  = 96;
    localparam int LIFE_LSB  = 97;
    localparam int GCID_LSB  = LIFE_LSB + NB_CELL_COUNT_WIDTH;
    localparam int ELEM_LSB  = GCID_LSB + GCID_W;
    localparam int PARID_LSB = ELEM_LSB + ELEMENT_WIDTH;
    localparam int PKT_ELEM  = 3*OFFSET_WIDTH;
    localparam int PKT_PARID = PKT_ELEM + ELEMENT_WIDTH;

    logic [AXIS_TDATA_WIDTH-1:0] acc_q, acc_d;
    logic [FILL_W-1:0]           fill_q, fill_d;
    logic                        acc_full_q, acc_full_d;
    logic [AXIS_TDATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                        out_last_q, out_last_d;
    logic                        out_valid_q, out_valid_d;
    logic [31:0]                 beat_cnt_q, beat_cnt_d;

    logic [SUB_PACKET_WIDTH-1:0] slot_new;
    logic [AXIS_TDATA_WIDTH-1:0] acc_wr;
    logic [FILL_W-1:0]           wr_slot;
    logic                        accept;
    logic                        drain;
    logic                        out_free;

    function automatic logic beat_last(input logic [AXIS_TDATA_WIDTH-1:0] b);
        logic l;
        l = 1'b0;
        for (int unsigned s = 0; s < NUM_SUB_PACKETS; s++) begin
            l = l | b[s*SUB_PACKET_WIDTH + LAST_BIT];
        end
        return l;
    endfunction

    assign o_ready         = ~acc_full_q & ~rst;
    assign o_remote_tdata  = out_data_q;
    assign o_remote_tvalid = out_valid_q;
    assign o_remote_tlast  = out_last_q;
    assign o_beat_cnt      = beat_cnt_q;

    always_comb begin
        slot_new = '0;
        slot_new[0  +: OFFSET_WIDTH] = i_offset_pkt[0              +: OFFSET_WIDTH];
        slot_new[32 +: OFFSET_WIDTH] = i_offset_pkt[OFFSET_WIDTH   +: OFFSET_WIDTH];
        slot_new[64 +: OFFSET_WIDTH] = i_offset_pkt[2*OFFSET_WIDTH +: OFFSET_WIDTH];
        slot_new[LAST_BIT]           = i_last;
        slot_new[LIFE_LSB  +: NB_CELL_COUNT_WIDTH] = i_lifetime;
        slot_new[GCID_LSB  +: GCID_W]              = i_gcid;
        slot_new[ELEM_LSB  +: ELEMENT_WIDTH]       = i_offset_pkt[PKT_ELEM  +: ELEMENT_WIDTH];
        slot_new[PARID_LSB +: PARTICLE_ID_WIDTH]   = i_offset_pkt[PKT_PARID +: PARTICLE_ID_WIDTH];

        // First sub-packet of a beat lands in the top slot.
        wr_slot = FILL_W'(NUM_SUB_PACKETS - 1) - fill_q;
        acc_wr  = acc_q;
        for (int unsigned s = 0; s < NUM_SUB_PACKETS; s++) begin
            if (FILL_W'(s) == wr_slot) begin
                acc_wr[s*SUB_PACKET_WIDTH +: SUB_PACKET_WIDTH] = slot_new;
            end
        end

        accept   = i_valid & o_ready;
        drain    = out_valid_q & i_remote_tready;
        out_free = ~out_valid_q | drain;

        acc_d       = acc_q;
        fill_d      = fill_q;
        acc_full_d  = acc_full_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q & ~drain;
        beat_cnt_d  = drain ? beat_cnt_q + 32'd1 : beat_cnt_q;

        if (acc_full_q) begin
            if (drain) begin
                out_data_d  = acc_q;
                out_last_d  = beat_last(acc_q);
                out_valid_d = 1'b1;
                acc_d       = '0;
                acc_full_d  = 1'b0;
            end
        end else if (accept) begin
            if (fill_q == FILL_W'(NUM_SUB_PACKETS - 1) || i_last) begin
                fill_d = '0;
                if (out_free) begin
                    out_data_d  = acc_wr;
                    out_last_d  = beat_last(acc_wr);
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                end else begin
                    acc_d      = acc_wr;
                    acc_full_d = 1'b1;
                end
            end else begin
                acc_d  = acc_wr;
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            fill_q      <= '0;
            acc_full_q  <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            beat_cnt_q  <= '0;
        end else begin
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            acc_full_q  <= acc_full_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_pos_to_remote_packer.sv
// Directed bench for pos_to_remote_packer with an expected-beat scoreboard.
module tb_pos_to_remote_packer;

    logic         clk;
    logic         rst;
    logic [97:0]  i_offset_pkt;
    logic [11:0]  i_gcid;
    logic [4:0]   i_lifetime;
    logic         i_last;
    logic         i_valid;
    logic         o_ready;
    logic [511:0] o_remote_tdata;
    logic         o_remote_tvalid;
    logic         o_remote_tlast;
    logic         i_remote_tready;
    logic [31:0]  o_beat_cnt;

    typedef struct {
        logic [511:0] d;
        logic         l;
    } beat_t;

    beat_t        sb_q[$];
    logic [511:0] m_beat;
    int           m_fill;
    logic         m_last;
    int           total;
    int           bad;
    logic         tog;
    logic         held_v;
    logic [511:0] held_d;

    pos_to_remote_packer #(
        .AXIS_TDATA_WIDTH(512),
        .NUM_SUB_PACKETS(4),
        .SUB_PACKET_WIDTH(128)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_offset_pkt(i_offset_pkt),
        .i_gcid(i_gcid),
        .i_lifetime(i_lifetime),
        .i_last(i_last),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .o_remote_tdata(o_remote_tdata),
        .o_remote_tvalid(o_remote_tvalid),
        .o_remote_tlast(o_remote_tlast),
        .i_remote_tready(i_remote_tready),
        .o_beat_cnt(o_beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chkw(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] enc(input logic [28:0] x, input logic [28:0] y,
                                         input logic [28:0] z, input logic [1:0] el,
                                         input logic [8:0] pid, input logic [11:0] g,
                                         input logic [4:0] life, input logic last);
        return {3'b000, pid, el, g, life, last, 3'b000, z, 3'b000, y, 3'b000, x};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) chkw("hold_stable", o_remote_tdata, held_d);
            if (o_remote_tvalid && i_remote_tready) begin
                chkb("beat_expected", sb_q.size() != 0, 1'b1);
                if (sb_q.size() != 0) begin
                    beat_t e;
                    e = sb_q.pop_front();
                    chkw("beat_data", o_remote_tdata, e.d);
                    chkb("beat_last", o_remote_tlast, e.l);
                end
            end
            held_v = o_remote_tvalid & ~i_remote_tready;
            held_d = o_remote_tdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (tog) i_remote_tready = ~i_remote_tready;
    endtask

    task automatic model_clear();
        sb_q.delete();
        m_beat = '0;
        m_fill = 0;
        m_last = 1'b0;
    endtask

    task automatic send(input logic [28:0] x, input logic [28:0] y, input logic [28:0] z,
                        input logic [1:0] el, input logic [8:0] pid, input logic [11:0] g,
                        input logic [4:0] life, input logic last);
        logic rdy;
        int   w;
        i_offset_pkt = {pid, el, z, y, x};
        i_gcid       = g;
        i_lifetime   = life;
        i_last       = last;
        i_valid      = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            rdy = o_ready;
            tick();
            w++;
        end while (!rdy && w < 300);
        chkb("accept_in_time", rdy, 1'b1);
        i_valid = 1'b0;
        if (rdy) begin
            m_beat[(3 - m_fill)*128 +: 128] = enc(x, y, z, el, pid, g, life, last);
            m_last = m_last | last;
            if (m_fill == 3 || last) begin
                beat_t b;
                b.d = m_beat;
                b.l = m_last;
                sb_q.push_back(b);
                m_beat = '0;
                m_fill = 0;
                m_last = 1'b0;
            end else begin
                m_fill++;
            end
        end
    endtask

    task automatic sendx(input int v, input logic last);
        logic [28:0] x;
        x = 29'(v);
        send(x, x + 29'd100, x + 29'd200, x[1:0], 9'(v * 7), 12'(v * 37 + 5),
             5'(v) | 5'd1, last);
    endtask

    task automatic wait_empty();
        int w;
        w = 0;
        while ((sb_q.size() != 0 || o_remote_tvalid) && w < 300) begin
            tick();
            w++;
        end
        chkb("drain_in_time", w < 300, 1'b1);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        chkb("rst_tvalid", o_remote_tvalid, 1'b0);
        chkb("rst_tlast", o_remote_tlast, 1'b0);
        chkb("rst_ready", o_ready, 1'b0);
        chkw("rst_tdata", o_remote_tdata, '0);
        chkw("rst_cnt", 512'(o_beat_cnt), '0);
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chkb("ready_after_rst", o_ready, 1'b1);
    endtask

    initial begin
        total = 0;
        bad = 0;
        tog = 1'b0;
        held_v = 1'b0;
        held_d = '0;
        rst = 1'b0;
        i_offset_pkt = '0;
        i_gcid = '0;
        i_lifetime = '0;
        i_last = 1'b0;
        i_valid = 1'b0;
        i_remote_tready = 1'b1;
        model_clear();
        #1 rst = 1'b1;
        #2;
        chkb("init_tvalid", o_remote_tvalid, 1'b0);
        chkb("init_tlast", o_remote_tlast, 1'b0);
        chkb("init_ready", o_ready, 1'b0);
        chkw("init_tdata", o_remote_tdata, '0);
        chkw("init_cnt", 512'(o_beat_cnt), '0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chkb("ready_after_init", o_ready, 1'b1);

        // Full beat of four, tready high.
        sendx(1, 1'b0);
        sendx(2, 1'b0);
        sendx(3, 1'b0);
        chkb("t1_no_early_valid", o_remote_tvalid, 1'b0);
        sendx(4, 1'b0);
        chkb("t1_valid", o_remote_tvalid, 1'b1);
        chkw("t1_slot3_x", 512'(o_remote_tdata[384 +: 29]), 512'(1));
        chkw("t1_slot0_x", 512'(o_remote_tdata[0 +: 29]), 512'(4));
        chkb("t1_tlast", o_remote_tlast, 1'b0);
        tick();
        chkw("t1_cnt", 512'(o_beat_cnt), 512'(1));
        wait_empty();

        // Partial beat closed by last.
        sendx(5, 1'b0);
        sendx(6, 1'b1);
        chkb("t2_valid", o_remote_tvalid, 1'b1);
        chkb("t2_tlast", o_remote_tlast, 1'b1);
        chkw("t2_low_zero", 512'(o_remote_tdata[255:0]), '0);
        chkb("t2_slot2_last", o_remote_tdata[256 + 96], 1'b1);
        chkb("t2_slot3_last", o_remote_tdata[384 + 96], 1'b0);
        wait_empty();

        // Every field at its maximum, alone in a beat.
        send('1, '1, '1, 2'd3, 9'd511, 12'hFFF, 5'd31, 1'b1);
        chkb("t3_valid", o_remote_tvalid, 1'b1);
        chkw("t3_slot3", 512'(o_remote_tdata[511:384]), 512'(128'h1FFF_FFFF_1FFF_FFFF_1FFF_FFFF_1FFF_FFFF));
        chkw("t3_pad_125", 512'(o_remote_tdata[384 + 125 +: 3]), '0);
        chkw("t3_pad_29", 512'(o_remote_tdata[384 + 29 +: 3]), '0);
        chkw("t3_parid", 512'(o_remote_tdata[384 + 116 +: 9]), 512'(9'h1FF));
        chkw("t3_lower", 512'(o_remote_tdata[383:0]), '0);
        wait_empty();

        // Backpressure: output plus one waiting beat, then stall.
        do_reset();
        i_remote_tready = 1'b0;
        for (int i = 0; i < 7; i++) sendx(10 + i, 1'b0);
        chkb("t4_ready_at7", o_ready, 1'b1);
        sendx(17, 1'b0);
        chkb("t4_ready_at8", o_ready, 1'b0);
        tick();
        chkb("t4_ready_held", o_ready, 1'b0);
        chkb("t4_tvalid_held", o_remote_tvalid, 1'b1);
        i_remote_tready = 1'b1;
        for (int i = 8; i < 12; i++) sendx(10 + i, 1'b0);
        wait_empty();
        chkw("t4_cnt", 512'(o_beat_cnt), 512'(3));

        // Streaming with tready toggling every cycle.
        tog = 1'b1;
        for (int i = 0; i < 16; i++) sendx(30 + i, 1'b0);
        tog = 1'b0;
        i_remote_tready = 1'b1;
        wait_empty();
        chkw("t5_cnt", 512'(o_beat_cnt), 512'(7));

        // Reset with a beat pending and a partial accumulator.
        i_remote_tready = 1'b0;
        for (int i = 0; i < 6; i++) sendx(50 + i, 1'b0);
        chkb("t6_pending", o_remote_tvalid, 1'b1);
        do_reset();
        i_remote_tready = 1'b1;
        for (int i = 0; i < 4; i++) sendx(60 + i, 1'b0);
        chkw("t6_slot3_x", 512'(o_remote_tdata[384 +: 29]), 512'(60));
        chkw("t6_slot0_x", 512'(o_remote_tdata[0 +: 29]), 512'(63));
        wait_empty();
        chkw("t6_cnt", 512'(o_beat_cnt), 512'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
